// File: rtl/encoder_fsm.sv
// Transmit-side frame controller: feeds each input word through the external
// calc unit, buffers results in arrival order and emits them as gap-free bursts.
module encoder_fsm #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  calc_start,
    output logic [DATA_WIDTH-1:0] calc_operand,
    input  logic                  calc_done,
    input  logic [DATA_WIDTH-1:0] calc_result,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  done,
    output logic                  busy
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ONE_COUNT    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_COUNT = FULL_COUNT - ONE_COUNT;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACCEPT    = 3'd1,
        S_CALC      = 3'd2,
        S_WAIT_CALC = 3'd3,
        S_EMIT      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t                  state_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_inc;
    logic [CNT_W-1:0]        count_reg;
    logic                    last_seen_reg;
    logic                    in_ready_reg;
    logic                    calc_start_reg;
    logic [DATA_WIDTH-1:0]   calc_operand_reg;
    logic                    out_valid_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic                    done_reg;
    logic                    busy_reg;
    logic                    buf_we;

    logic [DATA_WIDTH-1:0]   buf_mem [STACK_DEPTH];

    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
    assign buf_we     = rst_n && (state_reg == S_WAIT_CALC) && calc_done;

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_reg] <= calc_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            last_seen_reg    <= 1'b0;
            in_ready_reg     <= 1'b0;
            calc_start_reg   <= 1'b0;
            calc_operand_reg <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            done_reg         <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    last_seen_reg <= 1'b0;
                    count_reg     <= '0;
                    wr_ptr_reg    <= '0;
                    rd_ptr_reg    <= '0;
                    if (start) begin
                        state_reg    <= S_ACCEPT;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end

                // in_ready is always high here, so in_valid alone completes the handshake
                S_ACCEPT: begin
                    if (in_valid) begin
                        calc_operand_reg <= in_data;
                        last_seen_reg    <= in_last;
                        calc_start_reg   <= 1'b1;
                        in_ready_reg     <= 1'b0;
                        state_reg        <= S_CALC;
                    end
                end

                S_CALC: begin
                    calc_start_reg <= 1'b0;
                    state_reg      <= S_WAIT_CALC;
                end

                S_WAIT_CALC: begin
                    if (calc_done) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                        count_reg  <= count_reg + ONE_COUNT;
                        if (last_seen_reg || (count_reg == ALMOST_COUNT)) begin
                            state_reg     <= S_EMIT;
                            out_valid_reg <= 1'b1;
                            // An empty buffer means the first word is the one being written now
                            out_data_reg  <= (count_reg == '0) ? calc_result : buf_mem[rd_ptr_reg];
                        end else begin
                            state_reg    <= S_ACCEPT;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end

                S_EMIT: begin
                    rd_ptr_reg <= rd_ptr_inc;
                    count_reg  <= count_reg - ONE_COUNT;
                    if (count_reg == ONE_COUNT) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                        if (last_seen_reg) begin
                            state_reg <= S_FINISH;
                            done_reg  <= 1'b1;
                        end else begin
                            // Full-buffer flush: the same frame continues with a new burst
                            state_reg    <= S_ACCEPT;
                            in_ready_reg <= 1'b1;
                        end
                    end else begin
                        out_data_reg <= buf_mem[rd_ptr_inc];
                    end
                end

                S_FINISH: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg      <= S_IDLE;
                    in_ready_reg   <= 1'b0;
                    calc_start_reg <= 1'b0;
                    out_valid_reg  <= 1'b0;
                    out_data_reg   <= '0;
                    done_reg       <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_reg;
    assign calc_start   = calc_start_reg;
    assign calc_operand = calc_operand_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign done         = done_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_encoder_fsm.sv
// Bench for encoder_fsm: an emulated calc unit plus an output monitor, checked
// against frame-level expectations (result order and burst split by buffer depth).
module tb_encoder_fsm;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          calc_start;
    logic [DW-1:0] calc_operand;
    logic          calc_done;
    logic [DW-1:0] calc_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          done;
    logic          busy;

    logic          resp_done   = 1'b0;
    logic          spur_done   = 1'b0;
    logic [DW-1:0] resp_result = '0;
    int            calc_delay  = 1;
    logic [DW-1:0] calc_add    = '0;

    logic [DW-1:0] words [0:63];
    logic [DW-1:0] obs_q [$];
    int            burst_q [$];
    int            cur_len     = 0;
    int            done_cnt    = 0;
    int            done_orphan = 0;
    int            overlap_err = 0;
    logic          prev_ov     = 1'b0;

    int checks = 0;
    int errors = 0;

    assign calc_done   = resp_done | spur_done;
    assign calc_result = spur_done ? 32'hDEAD_BEEF : resp_result;

    always #5 clk = ~clk;

    encoder_fsm #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .calc_start(calc_start), .calc_operand(calc_operand),
        .calc_done(calc_done), .calc_result(calc_result),
        .out_valid(out_valid), .out_data(out_data), .done(done), .busy(busy)
    );

    // Emulated calc unit: result = operand + calc_add, calc_delay cycles after calc_start
    initial begin
        logic [DW-1:0] op;
        forever begin
            @(negedge clk);
            if (calc_start === 1'b1) begin
                op = calc_operand;
                repeat (calc_delay) @(negedge clk);
                resp_result = op + calc_add;
                resp_done   = 1'b1;
                @(negedge clk);
                resp_done   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_q.push_back(out_data);
            cur_len++;
        end else if (cur_len != 0) begin
            burst_q.push_back(cur_len);
            cur_len = 0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (prev_ov !== 1'b1) done_orphan++;
        end
        if (in_ready === 1'b1 && (out_valid === 1'b1 || calc_start === 1'b1 || done === 1'b1))
            overlap_err++;
        prev_ov = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_frame(input int n, input bit spur, output int tmo, output int lat_err);
        int t;
        tmo = 0;
        lat_err = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (spur) begin
            spur_done = 1'b1;
            repeat (2) @(negedge clk);
            spur_done = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            in_last  = (i == n - 1);
            t = 0;
            while (in_ready !== 1'b1 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                tmo = 1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            @(negedge clk);
            if (calc_start !== 1'b1) lat_err++;
        end
    endtask

    task automatic wait_done(input int base, output int tmo);
        tmo = 1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (done_cnt > base) begin
                tmo = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (calc_start !== 1'b0) begin errors++; $display("FAIL reset_calc_start: got %b expected 0", calc_start); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (calc_operand !== '0) begin errors++; $display("FAIL reset_calc_operand: got %h expected 0", calc_operand); end
        checks++; if (out_data !== '0)     begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        int ob, bb, db, tmo, tmo2, lat;
        ob = obs_q.size(); bb = burst_q.size(); db = done_cnt;
        calc_delay = 2;
        calc_add   = 32'h0000_1111 - 32'hA5A5_0001;
        words[0]   = 32'hA5A5_0001;
        run_frame(1, 1'b0, tmo, lat);
        wait_done(db, tmo2);
        checks++; if (tmo + tmo2 != 0) begin errors++; $display("FAIL single_timeout: got %0d expected 0", tmo + tmo2); end
        checks++; if (lat != 0) begin errors++; $display("FAIL single_calc_start_latency: got %0d late expected 0", lat); end
        checks++; if (obs_q.size() - ob != 1 || obs_q[ob] !== 32'h0000_1111) begin
            errors++; $display("FAIL single_data: got %0d words first %h expected 1 word 00001111", obs_q.size() - ob, (obs_q.size() > ob) ? obs_q[ob] : 32'h0);
        end
        checks++; if (burst_q.size() - bb != 1 || burst_q[bb] != 1) begin errors++; $display("FAIL single_burst: got %0d bursts expected one of length 1", burst_q.size() - bb); end
        checks++; if (done_cnt - db != 1 || done_orphan != 0) begin errors++; $display("FAIL single_done: got %0d dones %0d misplaced expected 1 and 0", done_cnt - db, done_orphan); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b done %b expected 0 0", busy, done); end
        $display("test_single_word: %0d word(s) out", obs_q.size() - ob);
    endtask

    task automatic test_three_word();
        int ob, bb, db, tmo, tmo2, lat, oe;
        logic [DW-1:0] exp_w;
        ob = obs_q.size(); bb = burst_q.size(); db = done_cnt; oe = overlap_err;
        calc_delay = 2;
        calc_add   = 32'h100;
        for (int i = 0; i < 3; i++) words[i] = i + 1;
        run_frame(3, 1'b0, tmo, lat);
        wait_done(db, tmo2);
        checks++; if (tmo + tmo2 != 0 || lat != 0) begin errors++; $display("FAIL three_handshake: got timeout %0d late %0d expected 0 0", tmo + tmo2, lat); end
        for (int i = 0; i < 3; i++) begin
            exp_w = 32'h100 + i + 1;
            checks++;
            if (obs_q.size() <= ob + i || obs_q[ob + i] !== exp_w) begin
                errors++; $display("FAIL three_data[%0d]: got %h expected %h", i, (obs_q.size() > ob + i) ? obs_q[ob + i] : 32'hx, exp_w);
            end
        end
        checks++; if (burst_q.size() - bb != 1 || burst_q[bb] != 3) begin errors++; $display("FAIL three_burst: got %0d bursts expected one of length 3", burst_q.size() - bb); end
        checks++; if (overlap_err != oe) begin errors++; $display("FAIL three_in_ready_low: got %0d overlaps expected 0", overlap_err - oe); end
        checks++; if (done_cnt - db != 1 || done_orphan != 0) begin errors++; $display("FAIL three_done: got %0d dones %0d misplaced expected 1 and 0", done_cnt - db, done_orphan); end
        $display("test_three_word: %0d word(s) out", obs_q.size() - ob);
    endtask

    task automatic test_overflow();
        int ob, bb, db, tmo, tmo2, lat;
        ob = obs_q.size(); bb = burst_q.size(); db = done_cnt;
        calc_delay = 1;
        calc_add   = $urandom;
        for (int i = 0; i < 20; i++) words[i] = $urandom;
        run_frame(20, 1'b0, tmo, lat);
        wait_done(db, tmo2);
        checks++; if (tmo + tmo2 != 0 || lat != 0) begin errors++; $display("FAIL overflow_handshake: got timeout %0d late %0d expected 0 0", tmo + tmo2, lat); end
        checks++; if (burst_q.size() - bb != 2 || burst_q[bb] != 16 || burst_q[bb + 1] != 4) begin
            errors++; $display("FAIL overflow_bursts: got %0d bursts first %0d expected 16 then 4", burst_q.size() - bb, (burst_q.size() > bb) ? burst_q[bb] : -1);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs_q.size() <= ob + i || obs_q[ob + i] !== words[i] + calc_add) begin
                errors++; $display("FAIL overflow_data[%0d]: got %h expected %h", i, (obs_q.size() > ob + i) ? obs_q[ob + i] : 32'hx, words[i] + calc_add);
            end
        end
        checks++; if (done_cnt - db != 1 || done_orphan != 0) begin errors++; $display("FAIL overflow_done: got %0d dones %0d misplaced expected 1 and 0", done_cnt - db, done_orphan); end
        $display("test_overflow: %0d word(s) in %0d burst(s)", obs_q.size() - ob, burst_q.size() - bb);
    endtask

    task automatic test_noise();
        int ob, bb, db, tmo, tmo2, lat, t;
        ob = obs_q.size(); bb = burst_q.size(); db = done_cnt;
        calc_delay = 6;
        calc_add   = 32'h55;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_frame(3, 1'b1, tmo, lat);
        t = 0;
        while (out_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        checks++; if (t >= 200) begin errors++; $display("FAIL noise_burst_start: got no out_valid within %0d cycles expected burst", t); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(db, tmo2);
        checks++; if (tmo + tmo2 != 0 || lat != 0) begin errors++; $display("FAIL noise_handshake: got timeout %0d late %0d expected 0 0", tmo + tmo2, lat); end
        checks++; if (obs_q.size() - ob != 3) begin errors++; $display("FAIL noise_count: got %0d words expected 3", obs_q.size() - ob); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q.size() <= ob + i || obs_q[ob + i] !== words[i] + 32'h55) begin
                errors++; $display("FAIL noise_data[%0d]: got %h expected %h", i, (obs_q.size() > ob + i) ? obs_q[ob + i] : 32'hx, words[i] + 32'h55);
            end
        end
        checks++; if (burst_q.size() - bb != 1 || done_cnt - db != 1) begin errors++; $display("FAIL noise_frame: got %0d bursts %0d dones expected 1 1", burst_q.size() - bb, done_cnt - db); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_restart_ignored: got busy %b expected 0", busy); end
        $display("test_noise: %0d word(s) out", obs_q.size() - ob);
    endtask

    task automatic test_reset_mid_burst();
        int ob, db, tmo, tmo2, lat, t;
        ob = obs_q.size(); db = done_cnt;
        calc_delay = 1;
        calc_add   = 32'h7;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_frame(4, 1'b0, tmo, lat);
        t = 0;
        while (out_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got out_valid %b done %b busy %b expected 0 0 0", out_valid, done, busy);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != db) begin errors++; $display("FAIL midrst_no_done: got %0d dones expected 0", done_cnt - db); end
        checks++; if (obs_q.size() - ob != 2 || obs_q[ob] !== words[0] + 32'h7) begin
            errors++; $display("FAIL midrst_partial: got %0d words expected 2 starting %h", obs_q.size() - ob, words[0] + 32'h7);
        end
        ob = obs_q.size();
        words[0] = $urandom;
        run_frame(1, 1'b0, tmo, lat);
        wait_done(db, tmo2);
        checks++; if (tmo + tmo2 != 0 || obs_q.size() - ob != 1 || obs_q[ob] !== words[0] + 32'h7) begin
            errors++; $display("FAIL midrst_fresh: got %0d words timeout %0d expected 1 word %h", obs_q.size() - ob, tmo + tmo2, words[0] + 32'h7);
        end
        $display("test_reset_mid_burst: fresh frame %0d word(s)", obs_q.size() - ob);
    endtask

    task automatic test_random();
        int ob, bb, db, tmo, tmo2, lat, n, nb, rem;
        int exp_b [$];
        for (int f = 0; f < 7; f++) begin
            n = (f == 0) ? DEPTH : (f == 1) ? 2 * DEPTH : int'($urandom_range(1, 40));
            ob = obs_q.size(); bb = burst_q.size(); db = done_cnt;
            calc_delay = $urandom_range(1, 4);
            calc_add   = $urandom;
            for (int i = 0; i < n; i++) words[i] = $urandom;
            exp_b.delete();
            rem = n;
            while (rem > 0) begin
                exp_b.push_back((rem > DEPTH) ? DEPTH : rem);
                rem -= (rem > DEPTH) ? DEPTH : rem;
            end
            run_frame(n, 1'b0, tmo, lat);
            wait_done(db, tmo2);
            checks++; if (tmo + tmo2 != 0 || lat != 0) begin errors++; $display("FAIL rand%0d_handshake: got timeout %0d late %0d expected 0 0", f, tmo + tmo2, lat); end
            checks++; if (obs_q.size() - ob != n) begin errors++; $display("FAIL rand%0d_count: got %0d words expected %0d", f, obs_q.size() - ob, n); end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_q.size() <= ob + i || obs_q[ob + i] !== words[i] + calc_add) begin
                    errors++; $display("FAIL rand%0d_data[%0d]: got %h expected %h", f, i, (obs_q.size() > ob + i) ? obs_q[ob + i] : 32'hx, words[i] + calc_add);
                end
            end
            nb = burst_q.size() - bb;
            checks++; if (nb != exp_b.size()) begin errors++; $display("FAIL rand%0d_nbursts: got %0d expected %0d", f, nb, exp_b.size()); end
            for (int b = 0; b < exp_b.size() && b < nb; b++) begin
                checks++;
                if (burst_q[bb + b] != exp_b[b]) begin errors++; $display("FAIL rand%0d_burst[%0d]: got %0d expected %0d", f, b, burst_q[bb + b], exp_b[b]); end
            end
            checks++; if (done_cnt - db != 1 || done_orphan != 0) begin errors++; $display("FAIL rand%0d_done: got %0d dones %0d misplaced expected 1 0", f, done_cnt - db, done_orphan); end
            $display("test_random frame %0d: %0d words, %0d bursts, delay %0d", f, n, nb, calc_delay);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        test_reset();
        test_single_word();
        test_three_word();
        test_overflow();
        test_noise();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
